// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register-file back end.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPtr,
        StWdata,
        StRdata,
        StErr
    } state_e;

    localparam logic       I2C_ACK       = 1'b1;
    localparam logic       I2C_NACK      = 1'b0;
    localparam logic [7:0] I2C_IDLE_BYTE = 8'hFF;

    // True when a received pointer byte addresses an existing register.
    function automatic logic ptr_in_range(input logic [7:0] b, input int unsigned aw);
        return (aw >= 8) || ((32'(b) >> aw) == 32'd0);
    endfunction

endpackage

// File: rtl/i2c_slave_regfile_if.sv
// Byte-level event bus between the I2C slave FSM (master modport) and the
// register-file back end (slave modport), plus the host read / write-done side.
interface i2c_slave_regfile_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              start_evt;
    logic              stop_evt;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ack_valid;
    logic              rx_ack;
    logic              tx_req;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_rdata;
    logic              wr_done;

    modport master (
        output start_evt, stop_evt, rx_valid, rx_data, tx_req, host_addr,
        input  rx_ack_valid, rx_ack, tx_valid, tx_data, host_rdata, wr_done
    );

    modport slave (
        input  start_evt, stop_evt, rx_valid, rx_data, tx_req, host_addr,
        output rx_ack_valid, rx_ack, tx_valid, tx_data, host_rdata, wr_done
    );

endinterface

// File: rtl/i2c_regfile_mem.sv
// DEPTH x 8 register array: one synchronous write port, two combinational
// read ports (slave path and host path). Reset clears every entry.
// I2C_REGFILE_WRPROT_EN: exports regs[0] bit 0 as the write-protect flag.
module i2c_regfile_mem #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [7:0]        rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
`ifdef I2C_REGFILE_WRPROT_EN
    output logic [7:0]        rdata_b,
    output logic              wp
`else
    output logic [7:0]        rdata_b
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] regs [DEPTH];

    // Storage: synchronous clear on reset, single write port otherwise.
    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

`ifdef I2C_REGFILE_WRPROT_EN
    assign wp = regs[0][0];
`endif

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave register-file back end: turns START/STOP/byte/read-request events
// into pointer, write and auto-incrementing read accesses on a small array.
// I2C_REGFILE_WRPROT_EN: regs[0] bit 0 write-protects indices 1..DEPTH-1.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_,
    i2c_slave_regfile_if.slave bus
);

    state_e            state;
    logic [ADDR_W-1:0] ptr;
    logic              wr_seen;

    logic              rx_take;
    logic              tx_take;
    logic              wr_allowed;
    logic              mem_we;
    logic [7:0]        slave_rdata;
    logic [7:0]        host_rd;

`ifdef I2C_REGFILE_WRPROT_EN
    logic              wp;
`endif

    i2c_regfile_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_    (rst_),
        .we      (mem_we),
        .waddr   (ptr),
        .wdata   (bus.rx_data),
        .raddr_a (ptr),
        .rdata_a (slave_rdata),
        .raddr_b (bus.host_addr),
`ifdef I2C_REGFILE_WRPROT_EN
        .rdata_b (host_rd),
        .wp      (wp)
`else
        .rdata_b (host_rd)
`endif
    );

    // Event qualification: a START in the same cycle swallows byte and request.
    always_comb begin
        rx_take = bus.rx_valid && !bus.start_evt;
        tx_take = bus.tx_req && !bus.start_evt;
`ifdef I2C_REGFILE_WRPROT_EN
        wr_allowed = !wp || (ptr == '0);
`else
        wr_allowed = 1'b1;
`endif
        mem_we = !rst_ && rx_take && (state == StWdata) && wr_allowed;
    end

    // Transaction FSM with pointer, write tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_) begin
            state            <= StIdle;
            ptr              <= '0;
            wr_seen          <= 1'b0;
            bus.rx_ack_valid <= 1'b0;
            bus.rx_ack       <= I2C_NACK;
            bus.tx_valid     <= 1'b0;
            bus.tx_data      <= 8'h00;
            bus.host_rdata   <= 8'h00;
            bus.wr_done      <= 1'b0;
        end else begin
            bus.rx_ack_valid <= 1'b0;
            bus.tx_valid     <= 1'b0;
            bus.wr_done      <= 1'b0;
            bus.host_rdata   <= host_rd;

            if (bus.start_evt) begin
                // Pointer and wr_seen survive a repeated START.
                state <= StPtr;
            end else begin
                if (rx_take) begin
                    bus.rx_ack_valid <= 1'b1;
                    case (state)
                        StPtr: begin
                            if (ptr_in_range(bus.rx_data, ADDR_W)) begin
                                ptr        <= bus.rx_data[ADDR_W-1:0];
                                bus.rx_ack <= I2C_ACK;
                                state      <= StWdata;
                            end else begin
                                bus.rx_ack <= I2C_NACK;
                                state      <= StErr;
                            end
                        end
                        StWdata: begin
                            // Protected writes are dropped but still advance the pointer.
                            ptr        <= ptr + 1'b1;
                            bus.rx_ack <= wr_allowed ? I2C_ACK : I2C_NACK;
                            if (wr_allowed) begin
                                wr_seen <= 1'b1;
                            end
                        end
                        StRdata: begin
                            bus.rx_ack <= I2C_NACK;
                            state      <= StErr;
                        end
                        default: begin
                            bus.rx_ack <= I2C_NACK;
                        end
                    endcase
                end

                if (tx_take) begin
                    bus.tx_valid <= 1'b1;
                    // A request colliding with a received byte is a protocol error.
                    if (!rx_take &&
                        (state == StPtr || state == StWdata || state == StRdata)) begin
                        bus.tx_data <= slave_rdata;
                        ptr         <= ptr + 1'b1;
                        state       <= StRdata;
                    end else begin
                        bus.tx_data <= I2C_IDLE_BYTE;
                    end
                end

                if (bus.stop_evt) begin
                    state       <= StIdle;
                    bus.wr_done <= wr_seen | mem_we;
                    wr_seen     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Scoreboard bench for i2c_slave_regfile: expected ack / tx bytes are queued
// with their due cycle when stimulus is driven and popped by a monitor.
// Define I2C_REGFILE_WRPROT_EN to also exercise write protection.
module tb_i2c_slave_regfile;

    localparam int unsigned ADDR_W = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  val;
    } exp_t;

    logic clk;
    logic rst_;
    int   cyc;
    int   n_chk;
    int   n_err;
    int   wr_done_cnt;
    int   exp_wr_done;
    exp_t ack_q[$];
    exp_t tx_q[$];
    exp_t mon_e;

    i2c_slave_regfile_if #(.ADDR_W(ADDR_W)) bus ();

    i2c_slave_regfile #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output pulse.
    always @(negedge clk) begin
        if (bus.rx_ack_valid) begin
            check_eq("ack_q_nonempty", 32'(ack_q.size() > 0), 32'd1);
            if (ack_q.size() > 0) begin
                mon_e = ack_q.pop_front();
                check_eq("ack_val", 32'(bus.rx_ack), 32'(mon_e.val));
                check_eq("ack_cycle", cyc, mon_e.cyc);
            end
        end
        if (bus.tx_valid) begin
            check_eq("tx_q_nonempty", 32'(tx_q.size() > 0), 32'd1);
            if (tx_q.size() > 0) begin
                mon_e = tx_q.pop_front();
                check_eq("tx_data", 32'(bus.tx_data), 32'(mon_e.val));
                check_eq("tx_cycle", cyc, mon_e.cyc);
            end
        end
        if (bus.wr_done) wr_done_cnt++;
    end

    // All drive tasks start and end #1 after a rising edge.
    task automatic ev(input logic s, input logic p, input logic rv, input logic [7:0] rd,
                      input logic tr);
        bus.start_evt = s;
        bus.stop_evt  = p;
        bus.rx_valid  = rv;
        bus.rx_data   = rd;
        bus.tx_req    = tr;
        @(posedge clk);
        #1;
        bus.start_evt = 1'b0;
        bus.stop_evt  = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_req    = 1'b0;
    endtask

    task automatic push_ack(input logic a);
        ack_q.push_back('{cyc: 32'(cyc + 1), val: {7'b0, a}});
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_q.push_back('{cyc: 32'(cyc + 1), val: d});
    endtask

    task automatic do_start();
        ev(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_stop();
        ev(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_rx(input logic [7:0] d, input logic a);
        push_ack(a);
        ev(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic do_tx(input logic [7:0] exp);
        push_tx(exp);
        ev(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic settle(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check_eq({tag, "_ack_pending"}, ack_q.size(), 0);
        check_eq({tag, "_tx_pending"}, tx_q.size(), 0);
        check_eq({tag, "_wr_done_cnt"}, wr_done_cnt, exp_wr_done);
        ack_q.delete();
        tx_q.delete();
    endtask

    task automatic host_chk(input int a, input logic [7:0] exp);
        bus.host_addr = 4'(a);
        @(posedge clk);
        @(negedge clk);
        check_eq($sformatf("host[%0d]", a), 32'(bus.host_rdata), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b0;
    endtask

    task automatic reset_outputs_chk(input string tag);
        @(negedge clk);
        check_eq({tag, "_rx_ack_valid"}, 32'(bus.rx_ack_valid), 0);
        check_eq({tag, "_rx_ack"}, 32'(bus.rx_ack), 0);
        check_eq({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
        check_eq({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        check_eq({tag, "_host_rdata"}, 32'(bus.host_rdata), 0);
        check_eq({tag, "_wr_done"}, 32'(bus.wr_done), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0; n_err = 0; wr_done_cnt = 0; exp_wr_done = 0; cyc = 0;
        rst_ = 1'b1;
        bus.start_evt = 1'b0; bus.stop_evt = 1'b0; bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00; bus.tx_req = 1'b0; bus.host_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_ = 1'b0;
        reset_outputs_chk("reset");
        host_chk(3, 8'h00);

        // Basic write burst with wr_done timing.
        do_start();
        do_rx(8'h03, 1'b1);
        do_rx(8'hA5, 1'b1);
        do_rx(8'h5A, 1'b1);
        do_stop();
        @(negedge clk);
        check_eq("t1_wr_done_pulse", 32'(bus.wr_done), 1);
        @(negedge clk);
        check_eq("t1_wr_done_once", 32'(bus.wr_done), 0);
        @(posedge clk);
        #1;
        exp_wr_done = 1;
        settle("t1");
        host_chk(3, 8'hA5);
        host_chk(4, 8'h5A);

        // Write pointer wrap.
        do_start();
        do_rx(8'h0F, 1'b1);
        do_rx(8'h11, 1'b1);
        do_rx(8'h22, 1'b1);
        do_stop();
        exp_wr_done = 2;
        settle("t2");
        host_chk(15, 8'h11);
        host_chk(0, 8'h22);

        // Repeated-START read, back-to-back requests, no wr_done.
        do_start();
        do_rx(8'h04, 1'b1);
        do_start();
        do_tx(8'h5A);
        do_tx(8'h00);
        do_stop();
        settle("t3");

        // Out-of-range pointer then NACK-ing in ERR.
        do_start();
        do_rx(8'h20, 1'b0);
        do_rx(8'h77, 1'b0);
        do_stop();
        settle("t4");
        host_chk(4, 8'h5A);
        host_chk(0, 8'h22);

        // START colliding with a byte: byte dropped, next byte is the pointer.
        ev(1'b1, 1'b0, 1'b1, 8'h09, 1'b0);
        do_rx(8'h02, 1'b1);
        do_rx(8'h33, 1'b1);
        do_stop();
        exp_wr_done = 3;
        settle("t5");
        host_chk(2, 8'h33);
        host_chk(9, 8'h00);

        // STOP together with the last data byte.
        do_start();
        do_rx(8'h07, 1'b1);
        push_ack(1'b1);
        ev(1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
        exp_wr_done = 4;
        settle("t6");
        host_chk(7, 8'h44);

        // Byte and read request together: byte wins, request answers 0xFF.
        do_start();
        do_rx(8'h08, 1'b1);
        push_ack(1'b1);
        push_tx(8'hFF);
        ev(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        do_stop();
        exp_wr_done = 5;
        settle("t7");
        host_chk(8, 8'h55);

        // ERR state answers reads with 0xFF.
        do_start();
        do_rx(8'h30, 1'b0);
        do_tx(8'hFF);
        do_rx(8'h12, 1'b0);
        do_stop();
        settle("t8");

        // Events outside a transaction.
        do_rx(8'h10, 1'b0);
        do_tx(8'hFF);
        settle("t9");

        // Read pointer wrap.
        do_start();
        do_rx(8'h0F, 1'b1);
        do_start();
        do_tx(8'h11);
        do_tx(8'h22);
        do_stop();
        settle("t10");

        // Reset mid-transaction: everything cleared, no wr_done.
        do_start();
        do_rx(8'h05, 1'b1);
        do_rx(8'h66, 1'b1);
        do_reset();
        reset_outputs_chk("t11");
        do_stop();
        settle("t11");
        for (int i = 0; i < 16; i++) host_chk(i, 8'h00);

`ifdef I2C_REGFILE_WRPROT_EN
        do_start();
        do_rx(8'h00, 1'b1);
        do_rx(8'h01, 1'b1);
        do_stop();
        exp_wr_done++;
        settle("wp_set");
        host_chk(0, 8'h01);
        do_start();
        do_rx(8'h02, 1'b1);
        do_rx(8'h99, 1'b0);
        do_rx(8'hAA, 1'b0);
        do_stop();
        settle("wp_block");
        host_chk(2, 8'h00);
        host_chk(3, 8'h00);
        do_start();
        do_rx(8'h00, 1'b1);
        do_rx(8'h03, 1'b1);
        do_rx(8'h44, 1'b0);
        do_stop();
        exp_wr_done++;
        settle("wp_idx0");
        host_chk(0, 8'h03);
        host_chk(1, 8'h00);
        do_start();
        do_rx(8'h05, 1'b1);
        do_rx(8'h10, 1'b0);
        do_reset();
        reset_outputs_chk("wp_rst");
        settle("wp_rst");
        for (int i = 0; i < 16; i++) host_chk(i, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Register-file back end directly downstream of the I2C slave FSM. It consumes the slave's byte-level events (START, STOP, received byte, read request) and turns them into register-pointer, write and auto-incrementing read accesses on a small on-chip register array. It also exposes a host-side read port and a write-done pulse to the rest of the chip.

## Interface
- `ADDR_W`, 4: register index width; the array holds DEPTH = 2**ADDR_W registers of 8 bits.
- `clk` in 1: single clock; every event input is sampled synchronous to it.
- `rst_` in 1: synchronous, active-high reset, despite the trailing underscore.
- `start_evt` in 1: one-cycle pulse on START or repeated START.
- `stop_evt` in 1: one-cycle pulse on STOP.
- `rx_valid` in 1: one-cycle pulse; `rx_data` holds a byte received in the write direction.
- `rx_data` in 8: received byte.
- `rx_ack_valid` out 1: one-cycle pulse qualifying `rx_ack`.
- `rx_ack` out 1: 1 = ACK, 0 = NACK for the last received byte.
- `tx_req` in 1: one-cycle pulse; the slave needs the next byte for a master read.
- `tx_valid` out 1: one-cycle pulse qualifying `tx_data`.
- `tx_data` out 8: byte to transmit.
- `host_addr` in ADDR_W: host read index.
- `host_rdata` out 8: registered contents of `regs[host_addr]`.
- `wr_done` out 1: one-cycle pulse after a STOP that closes a transaction containing at least one data write.

## Operation
- States:
  - IDLE: no transaction.
  - PTR: waiting for the pointer byte.
  - WDATA: writing data bytes.
  - RDATA: serving read bytes.
  - ERR: NACK-ing until the next START or STOP.
- IDLE + `start_evt` -> PTR. A START in any state -> PTR. The pointer is retained across a repeated START.
- PTR + `rx_valid`:
  - If `rx_data` < DEPTH: pointer := `rx_data[ADDR_W-1:0]`, ACK, -> WDATA.
  - Otherwise: NACK, -> ERR, pointer unchanged.
- PTR + `tx_req`: read at the current pointer, -> RDATA. This is the repeated-START read path.
- WDATA + `rx_valid`: `regs[ptr]` := `rx_data`, ACK, ptr := ptr+1, and the `wr_seen` flag is set.
- WDATA + `tx_req`: treated as a read at `ptr`, -> RDATA.
- RDATA + `tx_req`: `tx_data` := `regs[ptr]`, ptr := ptr+1.
- RDATA + `rx_valid`: NACK, no write, -> ERR.
- ERR: every `rx_valid` is NACK-ed and every `tx_req` returns 0xFF.
- IDLE + `rx_valid` or `tx_req`: NACK / 0xFF; the state does not change.
- Pointer wrap: DEPTH-1 increments to 0, on both the write and the read path.
- `stop_evt` in any state -> IDLE. If `wr_seen` is set, `wr_done` pulses; `wr_seen` is then cleared.
- Simultaneous events:
  - `start_evt` with `rx_valid` or `tx_req` in the same cycle: START wins. The byte or request is dropped; no ack pulse and no tx pulse are produced.
  - `stop_evt` with `rx_valid` in the same cycle: the byte is processed first (write plus ack), then the state goes to IDLE. `wr_done` includes that write.
  - `rx_valid` with `tx_req` in the same cycle: protocol violation. `rx_valid` is processed; `tx_req` returns 0xFF.
- Host port: `host_rdata` reflects a write in the same cycle with one cycle of lag. There is no bypass.

## Timing
- `rx_ack_valid`/`rx_ack`: registered, exactly 1 cycle after `rx_valid`.
- `tx_valid`/`tx_data`: registered, exactly 1 cycle after `tx_req`. The data reflects any write completed in an earlier cycle.
- Register write: takes effect at the `rx_valid` edge and is visible to `tx_req` on the next cycle.
- `wr_done`: 1 cycle after `stop_evt`.
- Back-to-back events, one per cycle, are supported at full rate.
- Reset values: state IDLE, ptr 0, all regs 0x00, `wr_seen` 0. Outputs reset to `rx_ack_valid` 0, `rx_ack` 0, `tx_valid` 0, `tx_data` 0x00, `host_rdata` 0x00, `wr_done` 0.
- Reset mid-transaction: abandons the transaction, clears everything, and produces no `wr_done`.

## Configuration
- `I2C_REGFILE_WRPROT_EN` defined: `regs[0]` bit 0 is write-protect.
  - While it is set, writes to index 1..DEPTH-1 are NACK-ed and dropped, and the pointer still increments.
  - Writes to index 0 are always allowed.
  - Dropped writes do not set `wr_seen`.
- `I2C_REGFILE_WRPROT_EN` undefined: `regs[0]` is an ordinary register and every in-range write is ACK-ed.

## Structure
- Shared package `i2c_pkg`:
  - state enum (IDLE, PTR, WDATA, RDATA, ERR).
  - `I2C_ACK`=1 and `I2C_NACK`=0.
  - `I2C_IDLE_BYTE`=8'hFF.
- Sub-module `i2c_regfile_mem`: DEPTH×8 array with one synchronous write port and two read ports, one for the slave path and one for the host. Reset clears all entries.
- Top level: FSM, pointer, `wr_seen`, and output registers.

## Test plan
- START, `rx` 0x03, `rx` 0xA5, `rx` 0x5A, STOP -> ACK ×3; regs[3]=0xA5, regs[4]=0x5A; `wr_done` pulses once, 1 cycle after STOP.
- START, `rx` 0x0F, `rx` 0x11, `rx` 0x22, STOP -> regs[15]=0x11, regs[0]=0x22 (wrap).
- START, `rx` 0x04, repeated START, `tx_req` ×2, STOP -> `tx_data` 0x5A then regs[5]; no `wr_done`.
- START, `rx` 0x20 (ADDR_W=4) -> NACK; a following `rx` 0x77 is NACK-ed; no register changes; no `wr_done`.
- `start_evt` and `rx_valid` in the same cycle, then `rx` 0x02 -> only one ack pulse, and 0x02 is taken as the pointer.
- With `I2C_REGFILE_WRPROT_EN`: write regs[0]=0x01, then write index 2 -> NACK and regs[2] unchanged; a `rst_` pulse mid-write -> all regs read 0 through `host_rdata`.
